coproc_cmd_if: RTL

Memory-mapped command front end for the image coprocessor. It accepts commands (func, gray, img_idx) written by the RISC-V core over the MMIO bus, buffers them in a small FIFO and issues each one to the coprocessor with a one-cycle `start` pulse when `rdy` is high. It then holds the command fields stable until `done` returns. It also exposes status, a completion counter and an optional completion interrupt back to the core.

---
 rtl/coproc_cmd_if.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/coproc_cmd_if.sv
// MMIO command front end for the image coprocessor: command FIFO, issue FSM,
// status/counter registers. Optional completion interrupt under `COPROC_IRQ_EN.
module coproc_cmd_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        start,
  output logic [2:0]  func,
  output logic        gray,
  output logic        img_idx,
  input  logic        rdy,
  input  logic        done,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q;
  logic             start_q;
  logic [2:0]       func_q;
  logic             gray_q;
  logic             img_q;
  logic [CNT_W-1:0] done_cnt_q;
  logic             done_flag_q;
  logic             ovf_q;
  logic [31:0]      rdata_q;

  logic [4:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic             full;
  logic             empty;
  logic             pop;
  logic             cmd_wr;
  logic             push;
  logic             ovf_set;
  logic             ctrl_wr;
  logic             complete;
  logic             irq_en;
  logic [4:0]       count5;
  logic [31:0]      status_w;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:5];

  // Handshake: a pop happens only in IDLE with rdy high; a push while full
  // is accepted only when the same edge pops.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    pop      = (state_q == S_IDLE) && !empty && rdy;
    cmd_wr   = we && (addr == 2'd0);
    push     = cmd_wr && (!full || pop);
    ovf_set  = cmd_wr && full && !pop;
    ctrl_wr  = we && (addr == 2'd2);
    complete = done && ((state_q == S_ISSUE) || (state_q == S_WAIT));
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      func_q      <= 3'd0;
      gray_q      <= 1'b0;
      img_q       <= 1'b0;
      done_cnt_q  <= '0;
      done_flag_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q                 <= S_ISSUE;
            start_q                 <= 1'b1;
            {img_q, gray_q, func_q} <= mem_q[rd_ptr_q];
          end
        end
        S_ISSUE: state_q <= done ? S_IDLE : S_WAIT;
        S_WAIT:  if (done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // A completion on the same edge as a clear keeps the flag set.
      if (complete) begin
        done_cnt_q  <= done_cnt_q + CNT_W'(1);
        done_flag_q <= 1'b1;
      end else if (ctrl_wr && wdata[0]) begin
        done_flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    count5   = 5'(count_q);
    status_w = {23'd0, count5[3:0], full, empty, ovf_q, done_flag_q,
                (state_q != S_IDLE)};
    rd_mux   = 32'd0;
    case (addr)
      2'd1:    rd_mux = status_w;
      2'd2:    rd_mux = {29'd0, irq_en, 2'b00};
      2'd3:    rd_mux = 32'(done_cnt_q);
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      if (ovf_set)                    ovf_q <= 1'b1;
      else if (ctrl_wr && wdata[1])   ovf_q <= 1'b0;
      if (re) rdata_q <= rd_mux;
    end
  end

`ifdef COPROC_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= wdata[2];
      irq_q <= irq_en_q & done_flag_q;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  assign rdata   = rdata_q;
  assign start   = start_q;
  assign func    = func_q;
  assign gray    = gray_q;
  assign img_idx = img_q;

endmodule
